mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 40 ++++
 rtl/mdu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl_pkg
// Purpose : Shared encodings for the multiply/divide unit controller.
//           Defines the mdop operation codes, the FSM state encoding and a
//           small helper that classifies long-latency operations.
// Revision: 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    // Operation codes presented on mdop alongside the E-stage start strobe.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } mdop_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    // True for the operations that occupy the unit for a multi-cycle period.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl
// Purpose : HI/LO multiply/divide unit with pipeline interlock. Results are
//           computed at issue, held for a fixed busy period, then committed
//           to the architectural HI/LO registers.
// Ports   : clk      - clock, rising edge
//           reset    - asynchronous active-low reset
//           start    - E-stage issue strobe (mdop/a/b valid this cycle)
//           mdop     - operation code (mdu_ctrl_pkg::mdop_t)
//           a, b     - rs / rt operands
//           d_is_md  - D-stage instruction is a multiply/divide-unit op
//           busy     - multiply/divide in progress
//           stall    - freeze PC/IF-ID, bubble ID-EX
//           hi, lo   - architectural HI/LO
//           rdata    - MFHI/MFLO read data
// Revision: 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] op_b;      // divisor kept to suppress the commit on divide-by-zero
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // ------------------------------------------------------------------
    // Arithmetic on the issue-cycle operands.
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // INT_MIN / -1 overflows a 32-bit signed divide; dividing by 1 instead
    // yields the architecturally expected quotient INT_MIN and remainder 0.
    // A zero divisor is also replaced so the divider never sees 0; its
    // result is discarded at completion anyway.
    logic               div_ovf;
    logic signed [31:0] sdiv_a;
    logic signed [31:0] sdiv_b;
    logic        [31:0] udiv_b;
    logic        [31:0] quot_s;
    logic        [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign div_ovf = (a == INT_MIN) && (b == NEG_ONE);
    assign sdiv_a  = a;
    assign sdiv_b  = ((b == 32'd0) || div_ovf) ? 32'sd1 : b;
    assign udiv_b  = (b == 32'd0) ? 32'd1 : b;
    assign quot_s  = sdiv_a / sdiv_b;
    assign rem_s   = sdiv_a % sdiv_b;
    assign quot_u  = a / udiv_b;
    assign rem_u   = a % udiv_b;

    // ------------------------------------------------------------------
    // Control FSM, counter and HI/LO in one block.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            op_b   <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (mdop)
                            MD_MULT: begin
                                res_hi <= prod_s[63:32];
                                res_lo <= prod_s[31:0];
                                op_b   <= b;
                                cnt    <= MULT_CNT;
                                state  <= S_MUL;
                            end
                            MD_MULTU: begin
                                res_hi <= prod_u[63:32];
                                res_lo <= prod_u[31:0];
                                op_b   <= b;
                                cnt    <= MULT_CNT;
                                state  <= S_MUL;
                            end
                            MD_DIV: begin
                                res_hi <= rem_s;
                                res_lo <= quot_s;
                                op_b   <= b;
                                cnt    <= DIV_CNT;
                                state  <= S_DIV;
                            end
                            MD_DIVU: begin
                                res_hi <= rem_u;
                                res_lo <= quot_u;
                                op_b   <= b;
                                cnt    <= DIV_CNT;
                                state  <= S_DIV;
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    // Any start seen here is ignored; the interlock keeps
                    // the pipeline from issuing one in normal flow.
                    if (cnt == 4'd0) begin
                        state <= S_IDLE;
                        if (!((state == S_DIV) && (op_b == 32'd0))) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs derived from current state; reads see committed HI/LO only.
    // ------------------------------------------------------------------
    assign busy  = (state != S_IDLE);
    assign stall = d_is_md & (busy | (start & is_muldiv(mdop)));

    always_comb begin
        rdata = 32'd0;
        if (mdop == MD_MFHI) begin
            rdata = hi;
        end else if (mdop == MD_MFLO) begin
            rdata = lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_ctrl
// Purpose : Self-checking bench for mdu_ctrl. Each multi-cycle operation
//           pushes its expected HI/LO and busy length into a scoreboard; a
//           monitor pops and compares when busy falls. Immediate effects
//           (reset values, MTHI/MTLO, rdata, stall) are checked inline.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    mdu_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset_n),
        .start   (start),
        .mdop    (mdop),
        .a       (a),
        .b       (b),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: a completed operation shows as busy falling after a run.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion actual=busy_run %0d required=none", busy_run);
            end else begin
                e = sb.pop_front();
                check("busy_len", 32'(busy_run), 32'(e.len));
                check("done_hi", hi, e.hi);
                check("done_lo", lo, e.lo);
            end
            busy_run = 0;
        end
    end

    // One-cycle issue: start/mdop/a/b presented for exactly one cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(posedge clk); #1;
        start = 1'b1; mdop = op; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; mdop = MD_NONE; a = 32'd0; b = 32'd0;
    endtask

    task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input int len);
        exp_t e;
        e.hi = eh; e.lo = el; e.len = len;
        sb.push_back(e);
    endtask

    // Present a read-type op for one cycle and check rdata mid-cycle.
    task automatic read_op(input string name, input logic [3:0] op, input logic [31:0] exp);
        @(posedge clk); #1;
        start = 1'b1; mdop = op;
        @(negedge clk);
        check(name, rdata, exp);
        @(posedge clk); #1;
        start = 1'b0; mdop = MD_NONE;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mdop = MD_NONE; a = 32'd0; b = 32'd0; d_is_md = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Signed and unsigned multiply.
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_LAT);
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        repeat (MULT_LAT + 3) @(posedge clk);
        push_exp(32'h0000_0001, 32'hFFFF_FFFE, MULT_LAT);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (MULT_LAT + 3) @(posedge clk);

        // Signed divide truncates toward zero, unsigned divide.
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (DIV_LAT + 3) @(posedge clk);
        push_exp(32'd1, 32'd3, DIV_LAT);
        issue(MD_DIVU, 32'd7, 32'd2);
        repeat (DIV_LAT + 3) @(posedge clk);

        // Reads and no-op starts.
        read_op("mfhi", MD_MFHI, 32'd1);
        read_op("mflo", MD_MFLO, 32'd3);
        read_op("none_rdata", MD_NONE, 32'd0);
        @(negedge clk);
        check("none_keeps_hi", hi, 32'd1);

        // Signed overflow case.
        push_exp(32'd0, 32'h8000_0000, DIV_LAT);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DIV_LAT + 3) @(posedge clk);

        // MTHI then divide by zero: HI/LO preserved.
        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        @(negedge clk);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        push_exp(32'h0000_1234, 32'h8000_0000, DIV_LAT);
        issue(MD_DIV, 32'd5, 32'd0);
        repeat (DIV_LAT + 3) @(posedge clk);

        issue(MD_MTLO, 32'h0000_CAFE, 32'd0);
        @(negedge clk);
        check("mtlo_lo", lo, 32'h0000_CAFE);

        // Interlock: MULT at T with a dependent D-stage md instruction.
        push_exp(32'd0, 32'd15, MULT_LAT);
        @(posedge clk); #1;
        start = 1'b1; mdop = MD_MULT; a = 32'd3; b = 32'd5; d_is_md = 1'b1;
        @(negedge clk);
        check("stall_T", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; mdop = MD_NONE; a = 32'd0; b = 32'd0;
        for (int i = 1; i <= MULT_LAT; i++) begin
            @(negedge clk);
            check($sformatf("stall_T+%0d", i), {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        start = 1'b1; mdop = MD_MFLO;
        @(negedge clk);
        check("stall_release", {31'd0, stall}, 32'd0);
        check("mflo_after_stall", rdata, 32'd15);
        @(posedge clk); #1;
        start = 1'b0; mdop = MD_NONE; d_is_md = 1'b0;
        repeat (2) @(posedge clk);

        // Start while busy is ignored.
        push_exp(32'd2, 32'd14, DIV_LAT);
        issue(MD_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        start = 1'b1; mdop = MD_MULT; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; mdop = MD_NONE; a = 32'd0; b = 32'd0;
        repeat (DIV_LAT + 4) @(posedge clk);
        @(negedge clk);
        check("ignored_busy", {31'd0, busy}, 32'd0);

        // Reset during the fourth busy cycle of a divide.
        issue(MD_DIV, 32'd50, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (DIV_LAT + 2) @(posedge clk);
        @(negedge clk);
        check("post_abort_busy", {31'd0, busy}, 32'd0);
        check("post_abort_hi", hi, 32'd0);
        check("post_abort_lo", lo, 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
